// File: rtl/lspc_svram_ctrl_pkg.sv
// Shared types and timing defaults for the LSPC slow-VRAM sequencer.
package svram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ACT   = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } svram_state_e;

  localparam int RD_CYCLES_DEF  = 3;
  localparam int WR_CYCLES_DEF  = 2;
  localparam int CPU_STARVE_DEF = 8;
  localparam int STARVE_W       = 4;
  localparam int CNT_W          = 4;

  localparam logic [STARVE_W-1:0] STARVE_MAX = 4'd15;

endpackage

// File: rtl/lspc_svram_ctrl_arb.sv
// Slow-VRAM arbiter: fetch normally wins, a CPU that has waited long enough wins instead.
module svram_arb
  import svram_pkg::*;
#(
  parameter int CPU_STARVE = CPU_STARVE_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_idle,
  input  logic i_fetch_req,
  input  logic i_cpu_req,
  output logic o_grant_fetch,
  output logic o_grant_cpu
);

  logic [STARVE_W-1:0] r_starve;
  logic                w_starved;

  assign w_starved = (r_starve >= STARVE_W'(CPU_STARVE));

  // Grant decision, only meaningful while the bus sequencer is idle
  always_comb begin
    o_grant_fetch = 1'b0;
    o_grant_cpu   = 1'b0;
    if (i_idle) begin
      if (w_starved && i_cpu_req) begin
        o_grant_cpu = 1'b1;
      end else if (i_fetch_req) begin
        o_grant_fetch = 1'b1;
      end else if (i_cpu_req) begin
        o_grant_cpu = 1'b1;
      end else begin
        o_grant_fetch = 1'b0;
        o_grant_cpu   = 1'b0;
      end
    end else begin
      o_grant_fetch = 1'b0;
      o_grant_cpu   = 1'b0;
    end
  end

  // Starve counter: counts every cycle the CPU asks but is not granted, including its own access
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_starve <= {STARVE_W{1'b0}};
    end else if (!i_cpu_req || o_grant_cpu) begin
      r_starve <= {STARVE_W{1'b0}};
    end else if (r_starve != STARVE_MAX) begin
      r_starve <= r_starve + STARVE_W'(1);
    end else begin
      r_starve <= r_starve;
    end
  end

endmodule

// File: rtl/lspc_svram_ctrl.sv
// LSPC slow-VRAM bus sequencer: serialises sprite fetches and 68k accesses onto the
// two 32Kx8 SRAMs with cycle-counted strobes; every output comes straight from a register.
module lspc_svram_ctrl
  import svram_pkg::*;
#(
  parameter int RD_CYCLES  = RD_CYCLES_DEF,
  parameter int WR_CYCLES  = WR_CYCLES_DEF,
  parameter int CPU_STARVE = CPU_STARVE_DEF
) (
  input  logic        CLK_24M,
  input  logic        RESET,
  input  logic        FETCH_REQ,
  input  logic [14:0] FETCH_ADDR,
  output logic        FETCH_ACK,
  output logic [15:0] FETCH_RDATA,
  input  logic        CPU_REQ,
  input  logic        CPU_WR,
  input  logic [14:0] CPU_ADDR,
  input  logic [15:0] CPU_WDATA,
  output logic        CPU_ACK,
  output logic [15:0] CPU_RDATA,
  output logic [14:0] SVRAM_ADDR,
  output logic [15:0] SVRAM_DQ_OUT,
  output logic        SVRAM_DQ_OE,
  input  logic [15:0] SVRAM_DQ_IN,
  output logic        nSVRAM_CE,
  output logic        nSVRAM_OE,
  output logic        nSVRAM_WE
);

  svram_state_e      r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_owner_cpu;
  logic              r_fetch_ack;
  logic              r_cpu_ack;
  logic [15:0]       r_fetch_rdata;
  logic [15:0]       r_cpu_rdata;
  logic [14:0]       r_addr;
  logic [15:0]       r_dq_out;
  logic              r_dq_oe;
  logic              r_nce;
  logic              r_noe;
  logic              r_nwe;
  logic              w_idle;
  logic              w_grant_fetch;
  logic              w_grant_cpu;

  assign w_idle = (r_state == ST_IDLE);

  svram_arb #(
    .CPU_STARVE (CPU_STARVE)
  ) u_arb (
    .i_clk         (CLK_24M),
    .i_reset       (RESET),
    .i_idle        (w_idle),
    .i_fetch_req   (FETCH_REQ),
    .i_cpu_req     (CPU_REQ),
    .o_grant_fetch (w_grant_fetch),
    .o_grant_cpu   (w_grant_cpu)
  );

  // Strobes for a phase are driven one edge after the state is entered, so ADDR/DQ settle with nCE high
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      r_state       <= ST_IDLE;
      r_cnt         <= {CNT_W{1'b0}};
      r_owner_cpu   <= 1'b0;
      r_fetch_ack   <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_fetch_rdata <= 16'h0000;
      r_cpu_rdata   <= 16'h0000;
      r_addr        <= 15'h0000;
      r_dq_out      <= 16'h0000;
      r_dq_oe       <= 1'b0;
      r_nce         <= 1'b1;
      r_noe         <= 1'b1;
      r_nwe         <= 1'b1;
    end else begin
      r_fetch_ack <= 1'b0;
      r_cpu_ack   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_dq_oe <= 1'b0;
          if (w_grant_cpu) begin
            r_owner_cpu <= 1'b1;
            r_addr      <= CPU_ADDR;
            if (CPU_WR) begin
              r_dq_out <= CPU_WDATA;
              r_state  <= ST_WR_SETUP;
            end else begin
              r_cnt   <= CNT_W'(RD_CYCLES);
              r_state <= ST_RD_ACT;
            end
          end else if (w_grant_fetch) begin
            r_owner_cpu <= 1'b0;
            r_addr      <= FETCH_ADDR;
            r_cnt       <= CNT_W'(RD_CYCLES);
            r_state     <= ST_RD_ACT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RD_ACT: begin
          if (r_cnt != {CNT_W{1'b0}}) begin
            r_nce <= 1'b0;
            r_noe <= 1'b0;
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            // Data is sampled on the same edge that releases nOE, so it is still driven
            r_nce   <= 1'b1;
            r_noe   <= 1'b1;
            r_state <= ST_IDLE;
            if (r_owner_cpu) begin
              r_cpu_rdata <= SVRAM_DQ_IN;
              r_cpu_ack   <= 1'b1;
            end else begin
              r_fetch_rdata <= SVRAM_DQ_IN;
              r_fetch_ack   <= 1'b1;
            end
          end
        end
        ST_WR_SETUP: begin
          r_nce   <= 1'b0;
          r_dq_oe <= 1'b1;
          r_cnt   <= CNT_W'(WR_CYCLES);
          r_state <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          r_nwe <= 1'b0;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt <= CNT_W'(1)) begin
            r_state <= ST_WR_HOLD;
          end else begin
            r_state <= ST_WR_PULSE;
          end
        end
        ST_WR_HOLD: begin
          r_nwe     <= 1'b1;
          r_nce     <= 1'b1;
          r_cpu_ack <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_nce   <= 1'b1;
          r_noe   <= 1'b1;
          r_nwe   <= 1'b1;
          r_dq_oe <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign FETCH_ACK    = r_fetch_ack;
  assign FETCH_RDATA  = r_fetch_rdata;
  assign CPU_ACK      = r_cpu_ack;
  assign CPU_RDATA    = r_cpu_rdata;
  assign SVRAM_ADDR   = r_addr;
  assign SVRAM_DQ_OUT = r_dq_out;
  assign SVRAM_DQ_OE  = r_dq_oe;
  assign nSVRAM_CE    = r_nce;
  assign nSVRAM_OE    = r_noe;
  assign nSVRAM_WE    = r_nwe;

endmodule

// File: doc/lspc_svram_ctrl.md
Name: lspc_svram_ctrl

Overview:
- Synchronous sequencer in the LSPC that owns the slow VRAM bus: one 15-bit address and one 16-bit word split across the low-byte and high-byte 120 ns 32K×8 SRAMs.
- Arbitrates the sprite-fetch read port and the 68k VRAM register read/write port.
- Drives ADDR/nCE/nOE/nWE with cycle-counted strobes so the SRAM access and write timing are always met.
- Sits directly upstream of the slow VRAM chips; the board-level tristate is built from SVRAM_DQ_OE.

Parameters:
RD_CYCLES, 3, cycles nCE+nOE held low before data is sampled (3×41.7 ns ≥ 120 ns)
WR_CYCLES, 2, cycles nWE held low (≥30 ns write pulse)
CPU_STARVE, 8, CPU wait cycles after which the CPU beats a pending fetch

Ports:
CLK_24M  in  1  single clock, 24 MHz
RESET  in  1  synchronous, active-high
FETCH_REQ  in  1  sprite-fetch read request, level
FETCH_ADDR  in  15  fetch word address
FETCH_ACK  out  1  one-cycle pulse; FETCH_RDATA valid this cycle
FETCH_RDATA  out  16  fetched word, held until the next fetch ACK
CPU_REQ  in  1  CPU access request, level
CPU_WR  in  1  1 = write, 0 = read
CPU_ADDR  in  15  CPU word address
CPU_WDATA  in  16  CPU write word
CPU_ACK  out  1  one-cycle pulse; access complete
CPU_RDATA  out  16  CPU read word, held until the next CPU read ACK
SVRAM_ADDR  out  15  SRAM address (both chips)
SVRAM_DQ_OUT  out  16  write data, [7:0] low chip, [15:8] high chip
SVRAM_DQ_OE  out  1  1 = controller drives the SRAM data bus
SVRAM_DQ_IN  in  16  SRAM read data
nSVRAM_CE  out  1  chip enable, active-low (both chips)
nSVRAM_OE  out  1  output enable, active-low
nSVRAM_WE  out  1  write enable, active-low

Behaviour:
- Reset values: nSVRAM_CE/OE/WE = 1; SVRAM_DQ_OE = 0; ACKs = 0; RDATA = 0; SVRAM_ADDR = 0; SVRAM_DQ_OUT = 0; starve counter = 0; state = IDLE.
- All outputs are registered.
- States: IDLE, RD_ACT, WR_SETUP, WR_PULSE, WR_HOLD. A down-counter times RD_ACT and WR_PULSE.
- Arbitration, in IDLE only, evaluated at edge t:
  - Fetch wins.
  - If starve counter ≥ CPU_STARVE and CPU_REQ is high, CPU wins.
  - The winner's address, data and direction are latched at t.
- Starve counter:
  - +1 (saturating at 15) every cycle CPU_REQ is high and the CPU is not granted.
  - Cleared on CPU grant and when CPU_REQ is low.
- Read, granted at t:
  - t+1 .. t+RD_CYCLES: RD_ACT; nCE = 0, nOE = 0, nWE = 1, DQ_OE = 0, ADDR stable.
  - Edge t+RD_CYCLES+1: SVRAM_DQ_IN is captured into the owner's RDATA; owner ACK = 1 for that cycle.
  - Same edge: strobes go high and state returns to IDLE.
- Write, granted at t:
  - t+1: WR_SETUP; nCE = 0, DQ_OE = 1, nWE = 1.
  - t+2 .. t+1+WR_CYCLES: WR_PULSE; nWE = 0.
  - Next cycle: WR_HOLD; nWE = 1, nCE = 1, DQ_OE still 1, CPU_ACK = 1.
  - Following cycle: IDLE, DQ_OE = 0.
- Fetch port is read-only. A fetch never writes.
- Invariants, checked by bench assertions:
  - nOE and nWE are never both low.
  - DQ_OE is never 1 while nOE = 0.
  - ADDR and DQ_OUT never change while nCE = 0.
- Handshake:
  - The requester holds REQ, ADDR and data stable until its ACK.
  - REQ still high in the cycle after ACK counts as a new request.
- Throughput: read = RD_CYCLES+2 cycles/access; write = WR_CYCLES+3 cycles.
- Simultaneous REQs with the counter below threshold: the fetch is served and the CPU waits. There is no preemption mid-access.
- RESET mid-access: next edge forces all strobes inactive and DQ_OE = 0. The access is abandoned with no ACK, RDATA is zeroed, and the requester must re-request.
- Addresses wrap naturally within 15 bits. There is no auto-increment here; the LSPC register logic owns VRAMMOD.

Decomposition:
- Package svram_pkg: state enum, default timing constants, and a STARVE_W width constant.
- Optional sub-module svram_arb: starve counter plus grant decision, about 40 lines. The FSM and datapath stay in lspc_svram_ctrl.

Test Plan:
- Fetch read, ADDR 15'h1234, SRAM model holds 16'hBEEF: ACK at t+4, FETCH_RDATA = 16'hBEEF, nOE low for exactly 3 cycles.
- CPU write 16'hA55A to 15'h7FFF, then a CPU read of 15'h7FFF: nWE low for 2 cycles with DQ_OE high from t+1 to t+4; CPU_RDATA = 16'hA55A.
- FETCH_REQ and CPU_REQ held high continuously: fetch served until the counter reaches 8, then one CPU grant, then the counter clears. Bench checks the grant sequence and no ACK overlap.
- Both REQs rise in the same cycle with the counter at 0: fetch ACK first; CPU_ACK exactly RD_CYCLES+2 (or the write length) cycles later.
- RESET asserted during the second nWE-low cycle: next cycle all strobes = 1, DQ_OE = 0, no CPU_ACK, state IDLE.
- Randomised back-to-back traffic with the invariant assertions active: zero violations over 10k cycles.
